memory_access_unit: RTL and testbench

- Memory-stage load/store engine between the execute/memory pipeline register and the data bus.
- Issues one bus transaction per valid load/store and aligns store data and byte enables.
- Aligns and sign- or zero-extends load data.
- Drives stallControl and loadDataValid into the hazard unit and raises misaligned/access-fault flags for the trap path.

---
 rtl/memory_access_unit_pkg.sv | 37 +++
 rtl/memory_access_unit_load_store_align.sv | 61 ++++++
 rtl/memory_access_unit.sv | 197 +++++++++++++++++++
 tb/tb_memory_access_unit.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_access_unit_pkg.sv
// Shared definitions for the memory-stage load/store engine.
//   - memoryState_ : access FSM state encoding
//   - F3_*         : funct3 encodings for loads and stores
//   - access_misaligned() : alignment rule shared by the FSM and its users
package memory_access_unit_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        MEM_IDLE    = 3'd0,
        MEM_REQUEST = 3'd1,
        MEM_WAIT    = 3'd2,
        MEM_DONE    = 3'd3,
        MEM_DRAIN   = 3'd4
    } memoryState_;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // funct3[1:0] encodes the access size for both loads and stores:
    // 00 byte, 01 halfword, anything else word.
    function automatic logic access_misaligned(input logic [2:0] funct3,
                                               input logic [1:0] addr_low);
        case (funct3[1:0])
            2'b00:   return 1'b0;
            2'b01:   return addr_low[0];
            default: return addr_low != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/memory_access_unit_load_store_align.sv
// Purely combinational data alignment for the memory stage.
//   store side: store_funct3_i, store_addr_low_i, store_i, store_data_i
//               -> store_data_o (lane-replicated), byte_enable_o
//   load side : load_funct3_i, load_addr_low_i, load_word_i
//               -> load_data_o (extracted and sign/zero-extended)
module load_store_align
    import memory_access_unit_pkg::*;
(
    input  logic [2:0]        store_funct3_i,
    input  logic [1:0]        store_addr_low_i,
    input  logic              store_i,
    input  logic [DATA_W-1:0] store_data_i,
    output logic [DATA_W-1:0] store_data_o,
    output logic [3:0]        byte_enable_o,
    input  logic [2:0]        load_funct3_i,
    input  logic [1:0]        load_addr_low_i,
    input  logic [DATA_W-1:0] load_word_i,
    output logic [DATA_W-1:0] load_data_o
);

    logic [DATA_W-1:0] load_shifted;

    // Narrow stores replicate the source into every lane so the selected
    // lane always carries the right bytes; the enables pick the lane.
    // Loads always read the full word.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and a latch is never inferred.
        store_data_o  = store_data_i;
        byte_enable_o = 4'b1111;
        if (store_i) begin
            case (store_funct3_i[1:0])
                2'b00: begin
                    store_data_o  = {4{store_data_i[7:0]}};
                    byte_enable_o = 4'b0001 << store_addr_low_i;
                end
                2'b01: begin
                    store_data_o  = {2{store_data_i[15:0]}};
                    byte_enable_o = 4'b0011 << store_addr_low_i;
                end
                default: begin
                    store_data_o  = store_data_i;
                    byte_enable_o = 4'b1111;
                end
            endcase
        end
    end

    // Move the addressed byte/halfword down to bit 0, then extend.
    always_comb begin
        load_shifted = load_word_i >> {load_addr_low_i, 3'b000};
        case (load_funct3_i)
            F3_LB:   load_data_o = {{24{load_shifted[7]}}, load_shifted[7:0]};
            F3_LH:   load_data_o = {{16{load_shifted[15]}}, load_shifted[15:0]};
            F3_LBU:  load_data_o = {24'd0, load_shifted[7:0]};
            F3_LHU:  load_data_o = {16'd0, load_shifted[15:0]};
            default: load_data_o = load_word_i;
        endcase
    end

endmodule

// File: rtl/memory_access_unit.sv
// Memory-stage load/store engine between the execute/memory pipeline
// register and the data bus. One bus transaction per live, aligned
// load/store; at most one outstanding.
//   pipeline in : memoryValid, memoryLoad, memoryStore, memoryFunct3,
//                 memoryAddress, memoryStoreData, memoryFlush
//   bus out     : busRequest, busWrite, busAddress, busWriteData, busByteEnable
//   bus in      : busReady, busResponseValid, busReadData, busError
//   hazard/trap : stallControl, loadDataValid, loadData, misaligned, accessFault
module memory_access_unit
    import memory_access_unit_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  memoryValid,
    input  logic                  memoryLoad,
    input  logic                  memoryStore,
    input  logic [2:0]            memoryFunct3,
    input  logic [ADDR_WIDTH-1:0] memoryAddress,
    input  logic [XLEN-1:0]       memoryStoreData,
    input  logic                  memoryFlush,
    output logic                  busRequest,
    output logic                  busWrite,
    output logic [ADDR_WIDTH-1:0] busAddress,
    output logic [XLEN-1:0]       busWriteData,
    output logic [3:0]            busByteEnable,
    input  logic                  busReady,
    input  logic                  busResponseValid,
    input  logic [XLEN-1:0]       busReadData,
    input  logic                  busError,
    output logic                  stallControl,
    output logic                  loadDataValid,
    output logic [XLEN-1:0]       loadData,
    output logic                  misaligned,
    output logic                  accessFault
);

    memoryState_           state_q,  state_d;
    logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
    logic [XLEN-1:0]       wdata_q,  wdata_d;
    logic [3:0]            be_q,     be_d;
    logic                  write_q,  write_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [XLEN-1:0]       rdata_q,  rdata_d;
    logic                  error_q,  error_d;

    logic                  mem_op;
    logic                  misaligned_c;
    logic                  access;
    logic                  stall_c;
    logic [XLEN-1:0]       align_wdata;
    logic [3:0]            align_be;
    logic [XLEN-1:0]       extracted;

    assign mem_op       = memoryValid & (memoryLoad | memoryStore);
    assign misaligned_c = mem_op & access_misaligned(memoryFunct3, memoryAddress[1:0]);
    assign access       = mem_op & ~misaligned_c;

    // Store side works on the live instruction (registered on issue);
    // load side works on the captured word and the registered low address
    // bits, so it is immune to the pipeline register changing later.
    load_store_align u_align (
        .store_funct3_i   (memoryFunct3),
        .store_addr_low_i (memoryAddress[1:0]),
        .store_i          (memoryStore),
        .store_data_i     (memoryStoreData),
        .store_data_o     (align_wdata),
        .byte_enable_o    (align_be),
        .load_funct3_i    (funct3_q),
        .load_addr_low_i  (addr_q[1:0]),
        .load_word_i      (rdata_q),
        .load_data_o      (extracted)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        write_d  = write_q;
        funct3_d = funct3_q;
        rdata_d  = rdata_q;
        error_d  = error_q;
        stall_c  = 1'b0;

        case (state_q)
            MEM_IDLE: begin
                if (access && !memoryFlush) begin
                    state_d  = MEM_REQUEST;
                    stall_c  = 1'b1;
                    addr_d   = memoryAddress;
                    wdata_d  = align_wdata;
                    be_d     = align_be;
                    write_d  = memoryStore;
                    funct3_d = memoryFunct3;
                end
            end

            MEM_REQUEST: begin
                stall_c = 1'b1;
                if (busReady) begin
                    // Once accepted the request cannot be withdrawn; a flush
                    // in the same cycle turns the result into a discard.
                    if (busResponseValid) begin
                        if (memoryFlush) begin
                            state_d = MEM_IDLE;
                        end else begin
                            rdata_d = busReadData;
                            error_d = busError;
                            state_d = MEM_DONE;
                        end
                    end else begin
                        state_d = memoryFlush ? MEM_DRAIN : MEM_WAIT;
                    end
                end else if (memoryFlush) begin
                    state_d = MEM_IDLE;
                end
            end

            MEM_WAIT: begin
                stall_c = 1'b1;
                if (busResponseValid) begin
                    if (memoryFlush) begin
                        state_d = MEM_IDLE;
                    end else begin
                        rdata_d = busReadData;
                        error_d = busError;
                        state_d = MEM_DONE;
                    end
                end else if (memoryFlush) begin
                    state_d = MEM_DRAIN;
                end
            end

            // Stall low here lets the pipeline advance on this edge; the
            // next instruction is only looked at from IDLE.
            MEM_DONE: begin
                state_d = MEM_IDLE;
            end

            MEM_DRAIN: begin
                stall_c = 1'b1;
                if (busResponseValid) begin
                    state_d = MEM_IDLE;
                end
            end

            default: begin
                state_d = MEM_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= MEM_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            write_q  <= 1'b0;
            funct3_q <= '0;
            rdata_q  <= '0;
            error_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            write_q  <= write_d;
            funct3_q <= funct3_d;
            rdata_q  <= rdata_d;
            error_q  <= error_d;
        end
    end

    // Bus fields are only meaningful while requesting; keep them quiet
    // otherwise.
    assign busRequest    = (state_q == MEM_REQUEST);
    assign busWrite      = busRequest & write_q;
    assign busAddress    = busRequest ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign busWriteData  = busRequest ? wdata_q : '0;
    assign busByteEnable = busRequest ? be_q : 4'b0000;

    assign loadDataValid = (state_q == MEM_DONE) & ~write_q & ~error_q;
    assign accessFault   = (state_q == MEM_DONE) & error_q;
    assign loadData      = loadDataValid ? extracted : '0;

    // The combinational paths from the live inputs are masked by reset so
    // that every output is 0 for as long as reset is held.
    assign stallControl  = stall_c & ~reset;
    assign misaligned    = misaligned_c & ~reset;

endmodule

// File: tb/tb_memory_access_unit.sv
module tb_memory_access_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        memoryValid, memoryLoad, memoryStore, memoryFlush;
    logic [2:0]  memoryFunct3;
    logic [31:0] memoryAddress, memoryStoreData;
    logic        busRequest, busWrite;
    logic [31:0] busAddress, busWriteData;
    logic [3:0]  busByteEnable;
    logic        busReady, busResponseValid, busError;
    logic [31:0] busReadData;
    logic        stallControl, loadDataValid, misaligned, accessFault;
    logic [31:0] loadData;

    int n_checks = 0;
    int n_bad    = 0;

    memory_access_unit #(.XLEN(32), .ADDR_WIDTH(32)) dut (
        .clock            (clock),
        .reset            (reset),
        .memoryValid      (memoryValid),
        .memoryLoad       (memoryLoad),
        .memoryStore      (memoryStore),
        .memoryFunct3     (memoryFunct3),
        .memoryAddress    (memoryAddress),
        .memoryStoreData  (memoryStoreData),
        .memoryFlush      (memoryFlush),
        .busRequest       (busRequest),
        .busWrite         (busWrite),
        .busAddress       (busAddress),
        .busWriteData     (busWriteData),
        .busByteEnable    (busByteEnable),
        .busReady         (busReady),
        .busResponseValid (busResponseValid),
        .busReadData      (busReadData),
        .busError         (busError),
        .stallControl     (stallControl),
        .loadDataValid    (loadDataValid),
        .loadData         (loadData),
        .misaligned       (misaligned),
        .accessFault      (accessFault)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int access_bytes(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic ref_misaligned(input logic [2:0] f3, input logic [31:0] a);
        return (a % access_bytes(f3)) != 0;
    endfunction

    function automatic logic [3:0] ref_be(input logic st, input logic [2:0] f3, input logic [31:0] a);
        int n;
        if (!st) return 4'hF;
        n = access_bytes(f3);
        return 4'(((1 << n) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        logic [31:0] m;
        m = 0;
        for (int i = 0; i < 4; i++) if (be[i]) m = m | (32'hFF << (8 * i));
        return m;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
        logic [31:0] v;
        logic [7:0]  b;
        logic [15:0] h;
        v = w >> (8 * (a % 4));
        b = v[7:0];
        h = v[15:0];
        case (f3)
            3'b000:  return 32'($signed(b));
            3'b001:  return 32'($signed(h));
            3'b100:  return 32'(b);
            3'b101:  return 32'(h);
            default: return w;
        endcase
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic quiet_inputs();
        memoryValid = 0; memoryLoad = 0; memoryStore = 0; memoryFlush = 0;
        memoryFunct3 = 0; memoryAddress = 0; memoryStoreData = 0;
        busReady = 0; busResponseValid = 0; busReadData = 0; busError = 0;
    endtask

    task automatic idle_cycle();
        @(negedge clock);
        quiet_inputs();
        #2;
        check("idle_stall", 32'(stallControl), 0);
        check("idle_req", 32'(busRequest), 0);
    endtask

    task automatic present(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        memoryValid = 1; memoryLoad = !st; memoryStore = st; memoryFlush = 0;
        memoryFunct3 = f3; memoryAddress = a; memoryStoreData = d;
        busReady = 0; busResponseValid = 0; busError = 0;
    endtask

    // One complete access: rdy_dly extra REQUEST cycles before busReady,
    // response resp_dly cycles after the ready cycle (0 = same cycle).
    task automatic do_access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] d, input int rdy_dly, input int resp_dly,
                             input logic [31:0] word, input logic err);
        int          stalls;
        logic        mis;
        logic        ldv;
        logic [3:0]  be;
        logic [31:0] m;
        stalls = 0;
        mis = ref_misaligned(f3, a);
        be  = ref_be(st, f3, a);
        m   = lane_mask(be);

        @(negedge clock);
        present(st, f3, a, d);
        #2;
        check("misaligned", 32'(misaligned), 32'(mis));
        check("issue_req", 32'(busRequest), 0);
        if (mis) begin
            check("mis_stall", 32'(stallControl), 0);
            @(negedge clock);
            #2;
            check("mis_req_hold", 32'(busRequest), 0);
            check("mis_stall_hold", 32'(stallControl), 0);
            return;
        end
        if (stallControl) stalls++;

        for (int k = 0; k <= rdy_dly; k++) begin
            @(negedge clock);
            busReady         = (k == rdy_dly);
            busResponseValid = (k == rdy_dly) && (resp_dly == 0);
            busReadData      = word;
            busError         = busResponseValid ? err : 1'b0;
            #2;
            check("req", 32'(busRequest), 1);
            check("addr", busAddress, a & ~32'h3);
            check("write", 32'(busWrite), 32'(st));
            check("be", 32'(busByteEnable), 32'(be));
            if (st) check("wdata", busWriteData & m, (d << (8 * (a % 4))) & m);
            if (stallControl) stalls++;
        end

        for (int k = 1; k <= resp_dly; k++) begin
            @(negedge clock);
            busReady         = 0;
            busResponseValid = (k == resp_dly);
            busReadData      = word;
            busError         = busResponseValid ? err : 1'b0;
            #2;
            check("wait_req", 32'(busRequest), 0);
            check("wait_ldv", 32'(loadDataValid), 0);
            if (stallControl) stalls++;
        end

        @(negedge clock);
        busReady = 0; busResponseValid = 0; busError = 0;
        #2;
        ldv = !st && !err;
        check("done_stall", 32'(stallControl), 0);
        check("stall_cycles", 32'(stalls), 32'(2 + rdy_dly + resp_dly));
        check("done_ldv", 32'(loadDataValid), 32'(ldv));
        check("done_data", loadData, ldv ? ref_load(f3, a, word) : 32'h0);
        check("done_fault", 32'(accessFault), 32'(err));
        check("done_req", 32'(busRequest), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"}, 32'(stallControl), 0);
        check({tag, "_req"},   32'(busRequest), 0);
        check({tag, "_wr"},    32'(busWrite), 0);
        check({tag, "_addr"},  busAddress, 0);
        check({tag, "_wdata"}, busWriteData, 0);
        check({tag, "_be"},    32'(busByteEnable), 0);
        check({tag, "_ldv"},   32'(loadDataValid), 0);
        check({tag, "_ld"},    loadData, 0);
        check({tag, "_mis"},   32'(misaligned), 0);
        check({tag, "_fault"}, 32'(accessFault), 0);
    endtask

    initial begin
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a;
        int          sel;

        quiet_inputs();
        reset = 1;
        #12;
        check_all_zero("reset");
        @(negedge clock);
        reset = 0;

        // Directed cases
        do_access(0, 3'b010, 32'h100, 0, 0, 1, 32'hDEADBEEF, 0);
        idle_cycle();
        do_access(0, 3'b000, 32'h103, 0, 1, 2, 32'h80FFFF7F, 0);
        do_access(0, 3'b100, 32'h103, 0, 0, 0, 32'h80FFFF7F, 0);
        do_access(1, 3'b001, 32'h202, 32'h1234ABCD, 0, 1, 0, 0);
        do_access(0, 3'b010, 32'h101, 0, 0, 0, 0, 0);
        idle_cycle();
        do_access(0, 3'b010, 32'h104, 0, 0, 2, 32'h12345678, 1);
        idle_cycle();

        // Flush while requesting: request withdrawn
        @(negedge clock);
        present(0, 3'b010, 32'h280, 0);
        #2;
        check("fr_idle_stall", 32'(stallControl), 1);
        @(negedge clock);
        memoryFlush = 1;
        #2;
        check("fr_req", 32'(busRequest), 1);
        @(negedge clock);
        quiet_inputs();
        busReady = 1;
        #2;
        check("fr_withdrawn", 32'(busRequest), 0);
        check("fr_stall", 32'(stallControl), 0);

        // Flush while waiting: response drained, nothing reported
        @(negedge clock);
        present(0, 3'b010, 32'h300, 0);
        @(negedge clock);
        busReady = 1;
        #2;
        check("fw_req", 32'(busRequest), 1);
        @(negedge clock);
        busReady = 0; memoryFlush = 1;
        #2;
        check("fw_wait_stall", 32'(stallControl), 1);
        @(negedge clock);
        quiet_inputs();
        #2;
        check("fw_drain_stall", 32'(stallControl), 1);
        @(negedge clock);
        busResponseValid = 1; busReadData = 32'h55;
        #2;
        check("fw_resp_stall", 32'(stallControl), 1);
        check("fw_resp_ldv", 32'(loadDataValid), 0);
        @(negedge clock);
        busResponseValid = 0;
        #2;
        check("fw_after_stall", 32'(stallControl), 0);
        check("fw_after_ldv", 32'(loadDataValid), 0);
        check("fw_after_fault", 32'(accessFault), 0);

        // Reset in WAIT: outputs clear immediately, late response ignored
        @(negedge clock);
        present(0, 3'b010, 32'h400, 0);
        @(negedge clock);
        busReady = 1;
        @(negedge clock);
        busReady = 0;
        #2;
        check("rw_wait_stall", 32'(stallControl), 1);
        #1;
        reset = 1;
        #1;
        check_all_zero("rw");
        @(negedge clock);
        reset = 0;
        quiet_inputs();
        busResponseValid = 1; busReadData = 32'h1234; busError = 1;
        #2;
        check("rw_late_stall", 32'(stallControl), 0);
        @(negedge clock);
        busResponseValid = 0; busError = 0;
        #2;
        check("rw_late_ldv", 32'(loadDataValid), 0);
        check("rw_late_fault", 32'(accessFault), 0);
        check("rw_late_req", 32'(busRequest), 0);

        // Randomized accesses
        for (int n = 0; n < 80; n++) begin
            st = 1'($urandom_range(0, 1));
            if (st) begin
                f3 = 3'($urandom_range(0, 2));
            end else begin
                sel = $urandom_range(0, 4);
                f3 = (sel < 3) ? 3'(sel) : 3'(sel + 1);
            end
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~32'(access_bytes(f3) - 1);
            do_access(st, f3, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom, ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end

        idle_cycle();
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
